adc_spi_responder: RTL and testbench
====================================

# adc_spi_responder

SPI responder that emulates the 12-bit ADC seen by the PmodDPG1 SPI master on the acquisition board: CPOL=0, MSB first, 16-bit frame of 4 leading zeros followed by 12 data bits. It sits on the FPGA loopback/emulation path and feeds known samples to the SPI master and filter chain without the physical converter. A valid/ready sample input buffers the next value to transmit; status pulses report completed, aborted and underrun frames.

## Interface
- DATA_W, 12, sample width; frame length is DATA_W+4 bits
- SYNC_STAGES, 2, synchronizer flops on sclk and cs_n (≥2)
- FIFO_DEPTH, 4, sample FIFO entries, power of 2, ≥2; used only with ADC_SPI_RESP_FIFO_EN

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- sclk  in  1  SPI clock from master (asynchronous to clk)
- cs_n  in  1  chip select from master, active low
- miso  out  1  serial data to master, registered
- sample_in  in  DATA_W  next sample to transmit
- sample_valid  in  1  sample_in valid
- sample_ready  out  1  buffer can accept; transfer when valid && ready
- frame_done  out  1  one-cycle pulse: full frame transmitted
- frame_abort  out  1  one-cycle pulse: cs_n rose before frame completed
- underrun  out  1  one-cycle pulse: frame started with empty buffer

## Operation
- sclk and cs_n pass through SYNC_STAGES flops plus one edge-detect flop; sync flops reset to 0, so cs_n already low at reset release never starts a frame.
- Reset values: miso=0, sample_ready=1, frame_done=frame_abort=underrun=0, buffer empty, last-sample register=0, state IDLE.
- States: IDLE, SHIFT, WAIT_CS.
- IDLE: miso=0. Detected cs_n fall → load shift register {4'b0, sample}, rise counter=0, → SHIFT. Sample source: buffer head if non-empty (pop); else the sample being accepted in that same cycle (bypass, no underrun); else the last-sample register, with underrun pulse.
- Every loaded sample is copied to the last-sample register.
- SHIFT: miso = shift[MSB]. Detected sclk fall → shift left one bit. Detected sclk rise → rise counter+1; the rise completing bit DATA_W+4 → frame_done pulse, → WAIT_CS; later sclk edges are ignored.
- Simultaneous sclk and cs_n edges in one cycle: cs_n takes priority.
- SHIFT and cs_n rise → frame_abort pulse, → IDLE; the aborted sample is not re-queued.
- WAIT_CS: miso=0; cs_n rise → IDLE.
- sclk edges in IDLE are ignored. A cs_n fall in WAIT_CS cannot occur (cs_n is low there); a fall is only acted on in IDLE.
- Buffer (no macro): single holding register; sample_ready = empty. A pop and an accept in the same cycle are legal (ready is computed from registered state).
- Reset asserted mid-frame: all state cleared immediately; miso=0 asynchronously.

## Timing
- miso is updated exactly SYNC_STAGES+2 clk cycles after the cs_n fall or sclk fall at the pin (sync + edge detect + output register).
- Master requirement: sclk half-period and the cs_n-fall-to-first-rise delay ≥ SYNC_STAGES+4 clk. The current master (50 clk per half-period) meets this.
- Status pulses occur on the cycle after the qualifying edge is detected.
- sample_ready rises the cycle after the buffer is popped.

## Configuration
- ADC_SPI_RESP_FIFO_EN defined: the buffer is a FIFO_DEPTH-entry FIFO with circular pointers and a (log2(FIFO_DEPTH)+1)-bit count; sample_ready = count < FIFO_DEPTH. Accept and pop in the same cycle when full is legal only with ready=0, so no accept is taken. Entries leave in FIFO order.
- Undefined: single holding register as described under Operation; FIFO_DEPTH is ignored.

## Test plan
- Push 12'hA5C; master frame at 50 clk per half-period → master reads 16'h0A5C, frame_done one pulse, underrun=0, sample_ready back to 1.
- Frame with empty buffer after the 12'hA5C frame → 16'h0A5C repeated, underrun one pulse. First frame after reset with empty buffer → 16'h0000.
- cs_n raised after 7 sclk rises → frame_abort pulse, no frame_done; next frame sends the next queued sample.
- sample_valid asserted in the same cycle the cs_n fall is detected, buffer empty → the frame carries that sample, no underrun.
- rst_n pulsed low during bit 9 while cs_n stays low → miso=0 at once, no frame until cs_n toggles high then low. FIFO build: push 12'h001..12'h005 → 5th push stalls (ready=0); frames return 1, 2, 3, 4 in order.

Source files
------------

// File: rtl/adc_spi_responder.sv
// SPI responder emulating the PmodDPG1 12-bit ADC: CPOL=0, MSB first, 4 zeros then DATA_W data bits.
// Define ADC_SPI_RESP_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
module adc_spi_responder #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    output logic              miso,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              frame_done,
    output logic              frame_abort,
    output logic              underrun
);
    localparam int FRAME_W = DATA_W + 4;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        WAIT_CS = 2'd2
    } state_t;

    if (SYNC_STAGES < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("adc_spi_responder: SYNC_STAGES must be >= 2, FIFO_DEPTH a power of 2 >= 2");
    end

    // ------------------------------------------------------------------
    // Synchronizers and edge detection on the asynchronous SPI inputs
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync;
    logic                   sclk_prev, cs_prev;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    // NOTE: sequential state uses <= so every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            cs_prev   <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_rise =  sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
    assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] &  sclk_prev;
    assign cs_rise   =  cs_sync[SYNC_STAGES-1]   & ~cs_prev;
    assign cs_fall   = ~cs_sync[SYNC_STAGES-1]   &  cs_prev;

    // ------------------------------------------------------------------
    // Sample buffer
    // ------------------------------------------------------------------
    logic              buf_empty;
    logic [DATA_W-1:0] buf_head;
    logic              accept, load, pop, store;

    assign accept = sample_valid & sample_ready;
    assign pop    = load & ~buf_empty;
    // A sample bypassed straight into the shift register is not also stored.
    assign store  = accept & ~(load & buf_empty);

`ifdef ADC_SPI_RESP_FIFO_EN
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_FW = PTR_W + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_FW-1:0] count;

    // NOTE: the storage array has no reset; count gates every read, so stale entries are never used.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_FW'(store) - CNT_FW'(pop);
        end
    end

    assign sample_ready = (count < CNT_FW'(FIFO_DEPTH));
    assign buf_empty    = (count == '0);
    assign buf_head     = mem[rd_ptr];
`else
    logic              buf_valid;
    logic [DATA_W-1:0] buf_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
        end else begin
            if (pop) begin
                buf_valid <= 1'b0;
            end
            if (store) begin
                buf_valid <= 1'b1;
                buf_data  <= sample_in;
            end
        end
    end

    assign sample_ready = ~buf_valid;
    assign buf_empty    = ~buf_valid;
    assign buf_head     = buf_data;
`endif

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t             state, state_next;
    logic [FRAME_W-1:0] shift, shift_next;
    logic [CNT_W-1:0]   rise_cnt, cnt_next;
    logic [DATA_W-1:0]  last_sample, load_sample;
    logic               miso_next, done_next, abort_next, underrun_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shift       <= '0;
            rise_cnt    <= '0;
            last_sample <= '0;
            miso        <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_next;
            shift       <= shift_next;
            rise_cnt    <= cnt_next;
            miso        <= miso_next;
            frame_done  <= done_next;
            frame_abort <= abort_next;
            underrun    <= underrun_next;
            if (load) begin
                last_sample <= load_sample;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        shift_next    = shift;
        cnt_next      = rise_cnt;
        load          = 1'b0;
        load_sample   = buf_head;
        done_next     = 1'b0;
        abort_next    = 1'b0;
        underrun_next = 1'b0;

        case (state)
            IDLE: begin
                if (cs_fall) begin
                    load = 1'b1;
                    if (!buf_empty) begin
                        load_sample = buf_head;
                    end else if (accept) begin
                        load_sample = sample_in;
                    end else begin
                        load_sample   = last_sample;
                        underrun_next = 1'b1;
                    end
                    shift_next = {4'b0000, load_sample};
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // cs_n has priority over an sclk edge detected in the same cycle.
                if (cs_rise) begin
                    abort_next = 1'b1;
                    state_next = IDLE;
                end else begin
                    if (sclk_fall) begin
                        shift_next = {shift[FRAME_W-2:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        cnt_next = rise_cnt + 1'b1;
                        if (rise_cnt == CNT_W'(FRAME_W - 1)) begin
                            done_next  = 1'b1;
                            state_next = WAIT_CS;
                        end
                    end
                end
            end
            WAIT_CS: begin
                if (cs_rise) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        miso_next = (state == SHIFT) ? shift[FRAME_W-1] : 1'b0;
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench for adc_spi_responder: a behavioural SPI master plus a sample scoreboard.
`timescale 1ns/1ps
module tb_adc_spi_responder;
    localparam int DATA_W      = 12;
    localparam int SYNC_STAGES = 2;
    localparam int FIFO_DEPTH  = 4;
    localparam int FRAME_W     = DATA_W + 4;
    localparam int HALF        = 50;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sclk = 1'b0;
    logic              cs_n = 1'b1;
    logic              miso;
    logic [DATA_W-1:0] sample_in = '0;
    logic              sample_valid = 1'b0;
    logic              sample_ready;
    logic              frame_done;
    logic              frame_abort;
    logic              underrun;

    adc_spi_responder #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .miso         (miso),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .frame_done   (frame_done),
        .frame_abort  (frame_abort),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    int ur_cnt = 0;

    // Scoreboard: samples the responder should send, in order, plus the repeat-on-underrun value.
    logic [DATA_W-1:0] sb_q [$];
    logic [DATA_W-1:0] last_s = '0;

    always @(negedge clk) begin
        if (frame_done)  done_cnt++;
        if (frame_abort) abort_cnt++;
        if (underrun)    ur_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_sample(input logic [DATA_W-1:0] v);
        int budget;
        budget = 200;
        @(negedge clk);
        while (!sample_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("push_ready", 32'(sample_ready), 32'd1);
        sample_in    = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        sb_q.push_back(v);
    endtask

    // Behavioural master: 50 clk half-period, samples miso just before each sclk rise.
    task automatic run_frame(input int rises, input logic bypass, input logic [DATA_W-1:0] byp_val,
                             output logic [15:0] word);
        word = '0;
        @(negedge clk);
        cs_n = 1'b0;
        if (bypass) begin
            wait_clk(2);
            sample_in    = byp_val;
            sample_valid = 1'b1;
            @(negedge clk);
            sample_valid = 1'b0;
            wait_clk(HALF - 3);
        end else begin
            wait_clk(HALF);
        end
        for (int i = 0; i < rises; i++) begin
            word = {word[14:0], miso};
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
            wait_clk(HALF);
        end
        cs_n = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic expect_frame(output logic [15:0] exp_word, output logic exp_ur);
        if (sb_q.size() > 0) begin
            last_s = sb_q.pop_front();
            exp_ur = 1'b0;
        end else begin
            exp_ur = 1'b1;
        end
        exp_word = {4'b0000, last_s};
    endtask

    task automatic frame_check(input string tag, input logic bypass, input logic [DATA_W-1:0] byp_val);
        int d0, a0, u0;
        logic [15:0] word, exp_word;
        logic exp_ur;
        d0 = done_cnt;
        a0 = abort_cnt;
        u0 = ur_cnt;
        if (bypass) sb_q.push_back(byp_val);
        expect_frame(exp_word, exp_ur);
        run_frame(FRAME_W, bypass, byp_val, word);
        check({tag, "_word"},     32'(word),          32'(exp_word));
        check({tag, "_done"},     32'(done_cnt - d0),  32'd1);
        check({tag, "_underrun"}, 32'(ur_cnt - u0),    32'(exp_ur));
        check({tag, "_abort"},    32'(abort_cnt - a0), 32'd0);
        check({tag, "_ready"},    32'(sample_ready),   32'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, a0, u0;
        logic [15:0] word;

        // Reset state
        wait_clk(5);
        check("rst_miso",      32'(miso),         32'd0);
        check("rst_ready",     32'(sample_ready), 32'd1);
        check("rst_done",      32'(frame_done),   32'd0);
        check("rst_abort",     32'(frame_abort),  32'd0);
        check("rst_underrun",  32'(underrun),     32'd0);
        rst_n = 1'b1;
        wait_clk(HALF);

        // First frame after reset, nothing buffered: zeros with underrun
        frame_check("first_empty", 1'b0, '0);

        // Normal frame, then an underrun frame repeating it
        push_sample(12'hA5C);
        check("ready_after_push", 32'(sample_ready), 32'd0);
        frame_check("a5c", 1'b0, '0);
        frame_check("repeat", 1'b0, '0);

        // Abort after 7 rises: 16'h0FA5 top 7 bits are 7'b0000111
        push_sample(12'hFA5);
        d0 = done_cnt;
        a0 = abort_cnt;
        u0 = ur_cnt;
        last_s = sb_q.pop_front();
        run_frame(7, 1'b0, '0, word);
        check("abort_pulse",    32'(abort_cnt - a0), 32'd1);
        check("abort_no_done",  32'(done_cnt - d0),  32'd0);
        check("abort_underrun", 32'(ur_cnt - u0),    32'd0);
        check("abort_partial",  32'(word),           32'h0007);
        push_sample(12'h456);
        frame_check("after_abort", 1'b0, '0);

        // Same-cycle bypass into an empty buffer
        frame_check("bypass", 1'b1, 12'h3C7);

        // Boundary and random data patterns
        push_sample(12'h800);
        frame_check("msb_only", 1'b0, '0);
        push_sample(12'h001);
        frame_check("lsb_only", 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            push_sample(12'($urandom));
            frame_check("random", 1'b0, '0);
        end

        // Reset during bit 9 with cs_n held low
        push_sample(12'hFFF);
        @(negedge clk);
        cs_n = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 8; i++) begin
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
            wait_clk(HALF);
        end
        check("bit9_miso", 32'(miso), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_miso", 32'(miso), 32'd0);
        sb_q.delete();
        last_s = '0;
        wait_clk(3);
        rst_n = 1'b1;
        d0 = done_cnt;
        u0 = ur_cnt;
        for (int i = 0; i < 4; i++) begin
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
            wait_clk(HALF);
        end
        check("held_cs_no_done",     32'(done_cnt - d0), 32'd0);
        check("held_cs_no_underrun", 32'(ur_cnt - u0),   32'd0);
        check("held_cs_miso",        32'(miso),          32'd0);
        cs_n = 1'b1;
        wait_clk(HALF);
        frame_check("post_reset", 1'b0, '0);

`ifdef ADC_SPI_RESP_FIFO_EN
        // Fill the FIFO, confirm the fifth push stalls, drain in order
        for (int i = 1; i <= 4; i++) push_sample(12'(i));
        @(negedge clk);
        check("fifo_full_ready", 32'(sample_ready), 32'd0);
        sample_in    = 12'h005;
        sample_valid = 1'b1;
        wait_clk(3);
        check("fifo_stall", 32'(sample_ready), 32'd0);
        sample_valid = 1'b0;
        for (int i = 0; i < 4; i++) frame_check("fifo_order", 1'b0, '0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
